// File: rtl/recur_accum_if.sv
// Stream, control and result bundle for the recursive shift-accumulator.
// The master drives run control and samples; the slave is the accumulator.
interface recur_accum_if #(
    parameter int W     = 32,
    parameter int IW    = 8,
    parameter int CNT_W = 8
);
    logic                    start;
    logic [CNT_W-1:0]        n_iter;
    logic [1:0]              shift;
    logic signed [IW-1:0]    in;
    logic                    in_valid;
    logic                    in_ready;
    logic signed [W-1:0]     y;
    logic                    y_valid;
    logic                    busy;
    logic                    done;
    logic                    ovf;

    modport master (
        output start, n_iter, shift, in, in_valid,
        input  in_ready, y, y_valid, busy, done, ovf
    );

    modport slave (
        input  start, n_iter, shift, in, in_valid,
        output in_ready, y, y_valid, busy, done, ovf
    );
endinterface

// File: rtl/recur_accum.sv
// Recursive shift-accumulator: y[n] = (y[n-1] << shift) + x[n] over n_iter samples,
// with start/busy/done control, valid/ready input and optional saturation.
//
// state | meaning
// IDLE  | waiting for start; y holds the last result
// RUN   | accepting samples, one per cycle when in_valid and en
// DONE  | single cycle with done high, then back to IDLE
module recur_accum #(
    parameter int W     = 32,
    parameter int IW    = 8,
    parameter int CNT_W = 8,
    parameter bit SAT   = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    recur_accum_if.slave bus
);
    localparam int SW = W + 4;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t               state;
    logic [CNT_W-1:0]     cnt;
    logic [CNT_W-1:0]     n_lat;
    logic [1:0]           sh_lat;
    logic signed [W-1:0]  y_q;
    logic                 y_valid_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 ovf_q;

    logic signed [SW-1:0] y_ext;
    logic signed [SW-1:0] in_ext;
    logic signed [SW-1:0] sum;
    logic signed [W-1:0]  y_next;
    logic                 out_of_range;

    // Sum in W+4 bits cannot itself overflow: |y << 3| + |x| < 2^(W+3).
    always_comb begin
        y_ext        = {{4{y_q[W-1]}}, y_q};
        in_ext       = {{(SW-IW){bus.in[IW-1]}}, bus.in};
        sum          = (y_ext <<< sh_lat) + in_ext;
        out_of_range = ~(&sum[SW-1:W-1]) & (|sum[SW-1:W-1]);
        y_next       = sum[W-1:0];
        if (SAT && out_of_range) begin
            y_next = sum[SW-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            n_lat     <= '0;
            sh_lat    <= '0;
            y_q       <= '0;
            y_valid_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else if (en) begin
            y_valid_q <= 1'b0;
            done_q    <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        y_q    <= '0;
                        ovf_q  <= 1'b0;
                        cnt    <= '0;
                        n_lat  <= bus.n_iter;
                        sh_lat <= bus.shift;
                        if (bus.n_iter != '0) begin
                            state  <= RUN;
                            busy_q <= 1'b1;
                        end else begin
                            state  <= DONE;
                            done_q <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (bus.in_valid) begin
                        y_q       <= y_next;
                        y_valid_q <= 1'b1;
                        cnt       <= cnt + 1'b1;
                        if (out_of_range) begin
                            ovf_q <= 1'b1;
                        end
                        // Last sample: done lands together with the final y_valid.
                        if (cnt == n_lat - 1'b1) begin
                            state  <= DONE;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready = busy_q & en;
    assign bus.y        = y_q;
    assign bus.y_valid  = y_valid_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.ovf      = ovf_q;
endmodule

// File: tb/tb_recur_accum.sv
// Scoreboard bench for recur_accum: three instances (32-bit saturating, 8-bit
// saturating, 8-bit wrapping) share one stimulus stream and are checked in parallel.
module tb_recur_accum;
    typedef struct {
        longint y;
        bit     ovf;
        bit     last;
    } exp_t;

    logic              clk;
    logic              rst;
    logic              en;
    logic              start;
    logic [7:0]        n_iter;
    logic [1:0]        shift;
    logic signed [7:0] sin;
    logic              in_valid;

    int     n_vec = 0;
    int     n_err = 0;
    exp_t   q[3][$];
    longint my[3];
    bit     mo[3];
    int     dc[3];
    int     yvc[3];
    int     exp_done = 0;
    int     wid[3] = '{32, 8, 8};
    bit     sat[3] = '{1'b1, 1'b1, 1'b0};
    int     cur_sh;
    int     rem;
    int     acc_cnt;

    recur_accum_if #(.W(32), .IW(8), .CNT_W(8)) ia ();
    recur_accum_if #(.W(8),  .IW(8), .CNT_W(8)) ib ();
    recur_accum_if #(.W(8),  .IW(8), .CNT_W(8)) ic ();

    assign ia.start = start;  assign ib.start = start;  assign ic.start = start;
    assign ia.n_iter = n_iter; assign ib.n_iter = n_iter; assign ic.n_iter = n_iter;
    assign ia.shift = shift;  assign ib.shift = shift;  assign ic.shift = shift;
    assign ia.in = sin;       assign ib.in = sin;       assign ic.in = sin;
    assign ia.in_valid = in_valid; assign ib.in_valid = in_valid; assign ic.in_valid = in_valid;

    recur_accum #(.W(32), .IW(8), .CNT_W(8), .SAT(1'b1)) dut_a (.clk(clk), .rst(rst), .en(en), .bus(ia));
    recur_accum #(.W(8),  .IW(8), .CNT_W(8), .SAT(1'b1)) dut_b (.clk(clk), .rst(rst), .en(en), .bus(ib));
    recur_accum #(.W(8),  .IW(8), .CNT_W(8), .SAT(1'b0)) dut_c (.clk(clk), .rst(rst), .en(en), .bus(ic));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint got, input longint want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    function automatic longint step(input longint prev, input int sh, input longint x,
                                    input int w, input bit s, output bit ov);
        longint sum, mx, mn, m;
        sum = prev * (longint'(1) << sh) + x;
        mx  = (longint'(1) << (w - 1)) - 1;
        mn  = -(longint'(1) << (w - 1));
        ov  = (sum > mx) || (sum < mn);
        if (!ov) return sum;
        if (s) return (sum > mx) ? mx : mn;
        m = sum & ((longint'(1) << w) - 1);
        if (m > mx) m = m - (longint'(1) << w);
        return m;
    endfunction

    task automatic mon(input int i, input logic yv, input longint y, input logic ov,
                       input logic dn, input logic bz);
        exp_t e;
        if (dn) dc[i]++;
        if (yv) begin
            yvc[i]++;
            if (q[i].size() == 0) begin
                chk($sformatf("unexpected_y_valid%0d", i), 1, 0);
            end else begin
                e = q[i].pop_front();
                chk($sformatf("y%0d", i), y, e.y);
                chk($sformatf("ovf%0d", i), longint'(ov), longint'(e.ovf));
                chk($sformatf("done_with_last%0d", i), longint'(dn), longint'(e.last));
                chk($sformatf("busy%0d", i), longint'(bz), longint'(!e.last));
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst === 1'b1) begin
            mon(0, ia.y_valid, longint'(ia.y), ia.ovf, ia.done, ia.busy);
            mon(1, ib.y_valid, longint'(ib.y), ib.ovf, ib.done, ib.busy);
            mon(2, ic.y_valid, longint'(ic.y), ic.ovf, ic.done, ic.busy);
        end
    end

    task automatic model_clear();
        for (int i = 0; i < 3; i++) begin
            my[i] = 0;
            mo[i] = 1'b0;
        end
    endtask

    task automatic start_run(input int n, input int sh);
        @(negedge clk);
        start  = 1'b1;
        n_iter = 8'(n);
        shift  = 2'(sh);
        en     = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        cur_sh  = sh;
        rem     = n;
        acc_cnt = 0;
        model_clear();
        if (n == 0) exp_done++;
    endtask

    task automatic send(input int v, input int gap);
        bit ov;
        bit last;
        for (int g = 0; g < gap; g++) @(negedge clk);
        in_valid = 1'b1;
        sin      = 8'(v);
        for (int t = 0; t < 20; t++) begin
            #1;
            if (ia.in_ready === 1'b1) begin
                last = (acc_cnt == rem - 1);
                acc_cnt++;
                if (last) exp_done++;
                for (int i = 0; i < 3; i++) begin
                    my[i] = step(my[i], cur_sh, longint'(sin), wid[i], sat[i], ov);
                    mo[i] = mo[i] | ov;
                    q[i].push_back('{my[i], mo[i], last});
                end
                @(negedge clk);
                in_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        chk("accept_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) @(negedge clk);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        int v0;
        rst = 1'b0; en = 1'b0; start = 1'b0; n_iter = '0; shift = '0; sin = '0; in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin dc[i] = 0; yvc[i] = 0; end
        model_clear();

        // reset with random inputs
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            start = 1'($urandom_range(0, 1)); n_iter = 8'($urandom); shift = 2'($urandom);
            sin = 8'($urandom); in_valid = 1'($urandom_range(0, 1)); en = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        #1;
        chk("rst_y_a", longint'(ia.y), 0);
        chk("rst_y_b", longint'(ib.y), 0);
        chk("rst_busy", longint'(ia.busy), 0);
        chk("rst_done", longint'(ia.done), 0);
        chk("rst_ovf", longint'(ia.ovf), 0);
        chk("rst_in_ready", longint'(ia.in_ready), 0);
        chk("rst_y_valid", longint'(ia.y_valid), 0);
        start = 1'b0; in_valid = 1'b0; en = 1'b1;
        rst = 1'b1;
        idle_cycles(2);

        // basic run: 1, 4, 11
        start_run(3, 1);
        send(1, 0); send(2, 0); send(3, 0);
        idle_cycles(2);
        chk("basic_final_y", longint'(ia.y), 11);

        // gaps and enable low mid-run: 1, 4, 11 again
        start_run(3, 1);
        send(1, 0);
        @(negedge clk);
        en = 1'b0;
        in_valid = 1'b1;
        sin = 8'sd2;
        v0 = yvc[0];
        @(negedge clk);
        #1;
        chk("en0_in_ready", longint'(ia.in_ready), 0);
        @(negedge clk);
        #1;
        chk("en0_y", longint'(ia.y), 1);
        chk("en0_busy", longint'(ia.busy), 1);
        chk("en0_no_y_valid", longint'(yvc[0]), longint'(v0));
        en = 1'b1;
        in_valid = 1'b0;
        send(2, 0); send(3, 2);
        idle_cycles(2);
        chk("en_final_y", longint'(ia.y), 11);

        // saturation / wrap: 100, 100
        start_run(2, 1);
        send(100, 0); send(100, 0);
        idle_cycles(3);
        chk("sat_y_b", longint'(ib.y), 127);
        chk("wrap_y_c", longint'(ic.y), 44);
        chk("ovf_sticky_b", longint'(ib.ovf), 1);
        chk("ovf_sticky_c", longint'(ic.ovf), 1);
        chk("ovf_clear_a", longint'(ia.ovf), 0);

        // n_iter = 0
        d0 = dc[0];
        v0 = yvc[0];
        start_run(0, 1);
        #1;
        chk("n0_done", longint'(ia.done), 1);
        chk("n0_y", longint'(ia.y), 0);
        chk("n0_ovf_b", longint'(ib.ovf), 0);
        idle_cycles(3);
        chk("n0_done_count", longint'(dc[0] - d0), 1);
        chk("n0_no_y_valid", longint'(yvc[0]), longint'(v0));

        // negative input, shift 3: -1, -9
        start_run(2, 3);
        send(-1, 0); send(-1, 0);
        idle_cycles(2);
        chk("neg_final_y_b", longint'(ib.y), -9);

        // random run
        start_run(6, $urandom_range(0, 3));
        for (int k = 0; k < 6; k++) send($urandom_range(0, 255), $urandom_range(0, 1));
        idle_cycles(2);

        // reset mid-run after 2 of 5 accepts
        start_run(5, 1);
        send(100, 0); send(100, 0);
        @(negedge clk);
        chk("midrst_queue_empty", longint'(q[0].size() + q[1].size() + q[2].size()), 0);
        d0 = dc[0];
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        model_clear();
        #1;
        chk("midrst_y_a", longint'(ia.y), 0);
        chk("midrst_y_b", longint'(ib.y), 0);
        chk("midrst_busy", longint'(ia.busy), 0);
        chk("midrst_ovf_b", longint'(ib.ovf), 0);
        chk("midrst_in_ready", longint'(ia.in_ready), 0);
        idle_cycles(3);
        chk("midrst_no_done", longint'(dc[0] - d0), 0);

        // clean run after reset: shift 0, 5, 6 -> 5, 11
        start_run(2, 0);
        send(5, 0); send(6, 0);
        idle_cycles(3);
        chk("post_rst_y_c", longint'(ic.y), 11);

        for (int i = 0; i < 3; i++) begin
            chk($sformatf("drain%0d", i), longint'(q[i].size()), 0);
            chk($sformatf("done_count%0d", i), longint'(dc[i]), longint'(exp_done));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
